// File: rtl/controladorbusqueda_if.sv
// rtl/controladorbusqueda_if.sv - fetch controller memory and decode-side bus
interface controladorbusqueda_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        fault;
    logic [31:0] fault_pc;

    modport master (
        output imem_addr, inst_valid, inst, inst_pc, fault, fault_pc,
        input  imem_data, redirect_valid, redirect_pc, halt, inst_ready
    );

    modport slave (
        input  imem_addr, inst_valid, inst, inst_pc, fault, fault_pc,
        output imem_data, redirect_valid, redirect_pc, halt, inst_ready
    );
endinterface

// File: rtl/controladorbusqueda.sv
// rtl/controladorbusqueda.sv - instruction fetch controller, 2-entry buffer, redirect/halt/fault
// Optional FETCH_PERF_EN adds perf_fetched / perf_stall counters.
module controladorbusqueda #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 128
) (
    input  logic                    clk,
    input  logic                    rst_n,
    controladorbusqueda_if.master   bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]             perf_fetched,
    output logic [31:0]             perf_stall
`endif
);
    localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

    typedef enum logic [1:0] {RST_WAIT, FETCH, HALTED, FAULT} state_e;

    state_e      state_q;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] buf_pc_q   [2];
    logic [31:0] buf_data_q [2];
    logic        fault_q;
    logic [31:0] fault_pc_q;

    logic pop, redirect, pc_ok, space, fetch_try, push, range_fault, stall, wr_idx;

    always_comb begin
        pop         = (count_q != 2'd0) && bus.inst_ready;
        redirect    = bus.redirect_valid && (state_q == FETCH || state_q == HALTED);
        pc_ok       = (pc_q[1:0] == 2'b00) && (pc_q <= LAST_PC);
        space       = (count_q != 2'd2) || pop;
        fetch_try   = (state_q == FETCH) && !redirect && !bus.halt;
        push        = fetch_try && pc_ok && space;
        range_fault = fetch_try && !pc_ok;
        stall       = fetch_try && pc_ok && !space;
        // After a same-cycle pop the new entry lands one slot lower.
        wr_idx      = (count_q == 2'd2) || (count_q == 2'd1 && !pop);

        count_d = count_q;
        pc_d    = pc_q;
        if (redirect) begin
            count_d = 2'd0;
            pc_d    = bus.redirect_pc;
        end else begin
            count_d = count_q - {1'b0, pop} + {1'b0, push};
            if (push) pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RST_WAIT;
            pc_q          <= RESET_PC;
            count_q       <= 2'd0;
            buf_pc_q[0]   <= '0;
            buf_pc_q[1]   <= '0;
            buf_data_q[0] <= '0;
            buf_data_q[1] <= '0;
            fault_q       <= 1'b0;
            fault_pc_q    <= '0;
        end else begin
            case (state_q)
                RST_WAIT: state_q <= FETCH;
                FETCH: begin
                    if (!redirect) begin
                        if (bus.halt)    state_q <= HALTED;
                        else if (!pc_ok) state_q <= FAULT;
                    end
                end
                HALTED: if (!redirect && !bus.halt) state_q <= FETCH;
                FAULT:  state_q <= FAULT;
            endcase

            if (range_fault) begin
                fault_q    <= 1'b1;
                fault_pc_q <= pc_q;
            end

            pc_q    <= pc_d;
            count_q <= count_d;

            if (pop) begin
                buf_pc_q[0]   <= buf_pc_q[1];
                buf_data_q[0] <= buf_data_q[1];
            end
            if (push) begin
                buf_pc_q[wr_idx]   <= pc_q;
                buf_data_q[wr_idx] <= bus.imem_data;
            end
        end
    end

    assign bus.imem_addr  = pc_q;
    assign bus.inst_valid = (count_q != 2'd0);
    assign bus.inst       = buf_data_q[0];
    assign bus.inst_pc    = buf_pc_q[0];
    assign bus.fault      = fault_q;
    assign bus.fault_pc   = fault_pc_q;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (push)  perf_fetched_q <= perf_fetched_q + 32'd1;
            if (stall) perf_stall_q   <= perf_stall_q + 32'd1;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`else
    logic unused_stall;
    assign unused_stall = stall;
`endif
endmodule

// File: tb/tb_controladorbusqueda.sv
// tb/tb_controladorbusqueda.sv - directed bench with queue-based reference model for controladorbusqueda
module tb_controladorbusqueda;
    logic clk;
    logic rst_n;
    controladorbusqueda_if bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stall;
`endif

    controladorbusqueda #(.RESET_PC(32'h0), .MEM_BYTES(128)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall)
`endif
    );

    logic [31:0] mem [0:31];
    assign bus.imem_data = mem[bus.imem_addr[6:2]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference model: mode 0=waiting after reset, 1=fetching, 2=halted, 3=faulted
    int          m_mode;
    logic [31:0] m_pc;
    logic [63:0] m_q [$];
    logic        m_fault;
    logic [31:0] m_fault_pc;
    logic [31:0] m_fetched, m_stall;
    logic [63:0] dut_got [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pc = 32'h0; m_q.delete();
        m_fault = 1'b0; m_fault_pc = 32'h0;
        m_fetched = 32'h0; m_stall = 32'h0;
    endtask

    task automatic model_step(input logic rv, input logic [31:0] rpc, input logic h, input logic rdy);
        bit pop;
        bit bad_pc;
        pop    = (m_q.size() > 0) && rdy;
        bad_pc = (m_pc % 4 != 0) || ({32'h0, m_pc} + 64'd4 > 64'd128);
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 3) begin
            if (pop) void'(m_q.pop_front());
        end else if (rv) begin
            m_q.delete();
            m_pc = rpc;
        end else if (m_mode == 2) begin
            if (pop) void'(m_q.pop_front());
            if (!h) m_mode = 1;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (h) m_mode = 2;
            else if (bad_pc) begin
                m_mode = 3; m_fault = 1'b1; m_fault_pc = m_pc;
            end else if (m_q.size() < 2) begin
                m_q.push_back({m_pc, mem[m_pc >> 2]});
                m_pc = m_pc + 32'd4;
                m_fetched = m_fetched + 32'd1;
            end else begin
                m_stall = m_stall + 32'd1;
            end
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic rv, input logic [31:0] rpc, input logic h, input logic rdy);
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.halt           = h;
        bus.inst_ready     = rdy;
        #1;
        if (bus.inst_valid && rdy) dut_got.push_back({bus.inst_pc, bus.inst});
        model_step(rv, rpc, h, rdy);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;
        bus.halt = 1'b0; bus.inst_ready = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("rst_inst_valid", 32'(bus.inst_valid), 32'h0);
        chk("rst_imem_addr", bus.imem_addr, 32'h0);
        chk("rst_fault", 32'(bus.fault), 32'h0);
        chk("rst_fault_pc", bus.fault_pc, 32'h0);
        chk("rst_inst", bus.inst, 32'h0);
        chk("rst_inst_pc", bus.inst_pc, 32'h0);
        model_reset();
        dut_got.delete();
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
    endtask

    task automatic chk_got(input int idx, input logic [31:0] epc, input logic [31:0] edata);
        if (idx < dut_got.size()) begin
            chk($sformatf("got_pc[%0d]", idx), dut_got[idx][63:32], epc);
            chk($sformatf("got_inst[%0d]", idx), dut_got[idx][31:0], edata);
        end else begin
            total++; bad++;
            $display("FAIL got_missing[%0d] actual=none required=%h", idx, epc);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("imem_addr", bus.imem_addr, m_pc);
            chk("inst_valid", 32'(bus.inst_valid), 32'(m_q.size() > 0));
            if (m_q.size() > 0) begin
                chk("inst_pc", bus.inst_pc, m_q[0][63:32]);
                chk("inst", bus.inst, m_q[0][31:0]);
            end
            chk("fault", 32'(bus.fault), 32'(m_fault));
            chk("fault_pc", bus.fault_pc, m_fault_pc);
`ifdef FETCH_PERF_EN
            chk("perf_fetched", perf_fetched, m_fetched);
            chk("perf_stall", perf_stall, m_stall);
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'hCAFE_0000 | 32'(i);
        rst_n = 1'b0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;
        bus.halt = 1'b0; bus.inst_ready = 1'b0;
        @(negedge clk);

        // free run from reset
        do_reset();
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("lat_valid_e1", 32'(bus.inst_valid), 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("lat_valid_e2", 32'(bus.inst_valid), 32'h1);
        chk("lat_pc_e2", bus.inst_pc, 32'h0);
        repeat (3) step(1'b0, 32'h0, 1'b0, 1'b1);
        chk_got(0, 32'h0, 32'hCAFE_0000);
        chk_got(1, 32'h4, 32'hCAFE_0001);
        chk_got(2, 32'h8, 32'hCAFE_0002);

        // backpressure
        do_reset();
        repeat (5) step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("bp_addr_hold", bus.imem_addr, 32'h8);
        chk("bp_none_taken", 32'(dut_got.size()), 32'h0);
        repeat (4) step(1'b0, 32'h0, 1'b0, 1'b1);
        chk_got(0, 32'h0, 32'hCAFE_0000);
        chk_got(1, 32'h4, 32'hCAFE_0001);
        chk_got(2, 32'h8, 32'hCAFE_0002);

        // redirect with full buffer and same-cycle pop
        do_reset();
        repeat (4) step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'h20, 1'b0, 1'b1);
        chk("rd_bubble", 32'(bus.inst_valid), 32'h0);
        chk("rd_addr", bus.imem_addr, 32'h20);
        repeat (2) step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("rd_count", 32'(dut_got.size()), 32'h2);
        chk_got(0, 32'h0, 32'hCAFE_0000);
        chk_got(1, 32'h20, 32'hCAFE_0008);

        // halt mid-stream
        do_reset();
        repeat (3) step(1'b0, 32'h0, 1'b0, 1'b1);
        repeat (4) step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("halt_addr", bus.imem_addr, 32'h8);
        chk("halt_drained", 32'(bus.inst_valid), 32'h0);
        repeat (4) step(1'b0, 32'h0, 1'b0, 1'b1);
        chk_got(0, 32'h0, 32'hCAFE_0000);
        chk_got(1, 32'h4, 32'hCAFE_0001);
        chk_got(2, 32'h8, 32'hCAFE_0002);
        chk_got(3, 32'hC, 32'hCAFE_0003);

        // range fault at end of memory
        do_reset();
        repeat (2) step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b1, 32'h7C, 1'b0, 1'b1);
        repeat (2) step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("range_fault", 32'(bus.fault), 32'h1);
        chk("range_fault_pc", bus.fault_pc, 32'h80);
        step(1'b1, 32'h0, 1'b0, 1'b1);
        chk("range_redirect_ignored", bus.imem_addr, 32'h80);
        chk("range_fault_held", 32'(bus.fault), 32'h1);
        chk_got(0, 32'h0, 32'hCAFE_0000);
        chk_got(1, 32'h7C, 32'hCAFE_001F);

        // misaligned redirect (reset also clears the sticky fault above)
        do_reset();
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b1, 32'h22, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("mis_fault", 32'(bus.fault), 32'h1);
        chk("mis_fault_pc", bus.fault_pc, 32'h22);
        chk("mis_valid", 32'(bus.inst_valid), 32'h0);
        repeat (2) step(1'b0, 32'h0, 1'b0, 1'b1);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
